// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads the system-ID peripheral's ID word (address 0) and
// timestamp word (address 1) over its Avalon-MM control slave. It compares both
// words against build-time values, re-reads on a mismatch, and reports the result.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   start               single-cycle request to run a check
//   sysid_address/read  master side of the sysid slave (sole master)
//   sysid_readdata      slave read data
//   busy, done          check in progress / one-cycle end-of-check pulse
//   pass                sticky result of the last check
//   id_match, ts_match  per-word compare results of the last sampled pair
//   id_value, ts_value  last sampled words
//   attempts            attempts used in the last or current check
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1463110960,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  attempts
);

  localparam logic [3:0] LatLast = 4'(READ_LATENCY);
  localparam logic [2:0] AttMax  = 3'(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StCheck,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [2:0]  attempts_q, attempts_d;
  logic        pass_q, pass_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  // Pending automatic start; consumed on the first edge after reset release.
  logic        auto_q;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;

  logic go;
  logic begin_check;
  logic id_eq;
  logic ts_eq;

  assign go    = start | auto_q;
  assign id_eq = (id_value_q == EXPECTED_ID);
  assign ts_eq = (ts_value_q == EXPECTED_TS);

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    attempts_d  = attempts_q;
    pass_d      = pass_q;
    id_match_d  = id_match_q;
    ts_match_d  = ts_match_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    begin_check = 1'b0;

    unique case (state_q)
      StIdle: begin
        begin_check = go;
      end
      StRdId: begin
        if (lat_q == LatLast) begin
          id_value_d = sysid_readdata;
          lat_d      = 4'd0;
          state_d    = StRdTs;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StRdTs: begin
        if (lat_q == LatLast) begin
          ts_value_d = sysid_readdata;
          lat_d      = 4'd0;
          state_d    = StCheck;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StCheck: begin
        id_match_d = id_eq;
        ts_match_d = ts_eq;
        if (id_eq && ts_eq) begin
          pass_d  = 1'b1;
          state_d = StDone;
        end else if (attempts_q < AttMax) begin
          // Increment only below the ceiling, so attempts saturates.
          attempts_d = attempts_q + 3'd1;
          state_d    = StRdId;
        end else begin
          pass_d  = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        // The done pulse for this cycle is already registered; a start here
        // chains straight into a new check.
        begin_check = go;
        if (!go) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (begin_check) begin
      state_d    = StRdId;
      lat_d      = 4'd0;
      attempts_d = 3'd1;
      pass_d     = 1'b0;
      id_match_d = 1'b0;
      ts_match_d = 1'b0;
    end
  end

  // Bus and status strobes are registered from the next state so they line up
  // with state_q without any decode glitches.
  always_comb begin
    busy_d = (state_d == StRdId) || (state_d == StRdTs) || (state_d == StCheck);
    done_d = (state_d == StDone);
    read_d = (state_d == StRdId) || (state_d == StRdTs);
    addr_d = (state_d == StRdTs);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lat_q      <= 4'd0;
      attempts_q <= 3'd0;
      pass_q     <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      auto_q     <= AUTO_START;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      attempts_q <= attempts_d;
      pass_q     <= pass_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      auto_q     <= 1'b0;
      busy_q     <= busy_d;
      done_q     <= done_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
    end
  end

  assign sysid_address = addr_q;
  assign sysid_read    = read_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign id_match      = id_match_q;
  assign ts_match      = ts_match_q;
  assign id_value      = id_value_q;
  assign ts_value      = ts_value_q;
  assign attempts      = attempts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench: instance a uses the default parameters (READ_LATENCY=1,
// MAX_RETRIES=3, AUTO_START=1). Instance b uses READ_LATENCY=0 and AUTO_START=0.
// Cycle counts are posedges counted from the negedge where start/reset release is
// applied.
module tb_sysid_check_ctrl;

  localparam logic [31:0] GoodTs = 32'd1463110960;
  localparam logic [31:0] BadTs  = 32'd1463110961;
  localparam logic [31:0] BadId  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a
  logic        rst_a, start_a, addr_a, read_a, busy_a, done_a, pass_a;
  logic        idm_a, tsm_a;
  logic [31:0] rdata_a, idv_a, tsv_a;
  logic [2:0]  att_a;
  logic [31:0] ts_word;
  logic        bad_id_req;
  logic        ts_seen;

  // Instance b
  logic        rst_b, start_b, addr_b, read_b, busy_b, done_b, pass_b;
  logic        idm_b, tsm_b;
  logic [31:0] rdata_b, idv_b, tsv_b;
  logic [2:0]  att_b;

  int n_vec = 0;
  int n_err = 0;

  // Slave model: a bad ID is returned only until the first timestamp read.
  always @(posedge clk or posedge rst_a)
    if (rst_a) ts_seen <= 1'b0;
    else if (read_a && addr_a) ts_seen <= 1'b1;

  assign rdata_a = addr_a ? ts_word : ((bad_id_req && !ts_seen) ? BadId : 32'd0);
  assign rdata_b = addr_b ? GoodTs : 32'd0;

  sysid_check_ctrl u_dut_a (
    .clock          (clk),
    .reset          (rst_a),
    .start          (start_a),
    .sysid_address  (addr_a),
    .sysid_read     (read_a),
    .sysid_readdata (rdata_a),
    .busy           (busy_a),
    .done           (done_a),
    .pass           (pass_a),
    .id_match       (idm_a),
    .ts_match       (tsm_a),
    .id_value       (idv_a),
    .ts_value       (tsv_a),
    .attempts       (att_a)
  );

  sysid_check_ctrl #(
    .READ_LATENCY (0),
    .AUTO_START   (1'b0)
  ) u_dut_b (
    .clock          (clk),
    .reset          (rst_b),
    .start          (start_b),
    .sysid_address  (addr_b),
    .sysid_read     (read_b),
    .sysid_readdata (rdata_b),
    .busy           (busy_b),
    .done           (done_b),
    .pass           (pass_b),
    .id_match       (idm_b),
    .ts_match       (tsm_b),
    .id_value       (idv_b),
    .ts_value       (tsv_b),
    .attempts       (att_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts posedges until done is seen at a negedge; returns max+1 on timeout.
  task automatic wait_done(input bit sel_b, input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if ((sel_b ? done_b : done_a) === 1'b1) return;
    end
    n = max + 1;
  endtask

  int n;
  int busy_cnt;

  initial begin
    rst_a = 1'b1; start_a = 1'b0; rst_b = 1'b1; start_b = 1'b0;
    ts_word = GoodTs; bad_id_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_read", read_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_pass", pass_a, 0);
    check_eq("rst_att", att_a, 0);
    check_eq("rst_tsv", tsv_a, 0);

    // Test 1: auto start, cycle-by-cycle bus sequence
    rst_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("t1_read_%0d", k), read_a, (k <= 4) ? 1 : 0);
      check_eq($sformatf("t1_addr_%0d", k), addr_a, (k == 3 || k == 4) ? 1 : 0);
      check_eq($sformatf("t1_busy_%0d", k), busy_a, (k <= 5) ? 1 : 0);
      check_eq($sformatf("t1_done_%0d", k), done_a, (k == 6) ? 1 : 0);
    end
    check_eq("t1_pass", pass_a, 1);
    check_eq("t1_att", att_a, 1);
    check_eq("t1_idv", idv_a, 0);
    check_eq("t1_tsv", tsv_a, GoodTs);
    @(negedge clk);
    check_eq("t1_done_drop", done_a, 0);

    // Test 2: timestamp always wrong, retries exhausted
    rst_a = 1'b1; ts_word = BadTs;
    @(negedge clk);
    rst_a = 1'b0;
    wait_done(1'b0, 40, n);
    check_eq("t2_cycles", n, 21);
    check_eq("t2_pass", pass_a, 0);
    check_eq("t2_idm", idm_a, 1);
    check_eq("t2_tsm", tsm_a, 0);
    check_eq("t2_att", att_a, 4);
    check_eq("t2_tsv", tsv_a, BadTs);

    // Test 3: ID wrong on the first attempt only
    rst_a = 1'b1; ts_word = GoodTs; bad_id_req = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    wait_done(1'b0, 40, n);
    check_eq("t3_cycles", n, 11);
    check_eq("t3_pass", pass_a, 1);
    check_eq("t3_att", att_a, 2);
    bad_id_req = 1'b0;

    // Test 4: READ_LATENCY=0, manual start, start during busy ignored
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t4_idle_busy", busy_b, 0);
    check_eq("t4_idle_read", read_b, 0);
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t4_busy", busy_b, 1);
    check_eq("t4_rd_addr0", addr_b, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t4_rd_addr1", addr_b, 1);
    start_b = 1'b0;
    wait_done(1'b1, 20, n);
    check_eq("t4_cycles", n + 2, 4);
    check_eq("t4_pass", pass_b, 1);
    check_eq("t4_tsv", tsv_b, GoodTs);
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy_b || done_b) busy_cnt++;
    end
    check_eq("t4_no_rerun", busy_cnt, 0);

    // Test 5: reset during RD_TS aborts asynchronously, auto start reruns
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("t5_in_rdts", addr_a, 1);
    #2 rst_a = 1'b1;
    #1;
    check_eq("t5_async_busy", busy_a, 0);
    check_eq("t5_async_read", read_a, 0);
    check_eq("t5_async_addr", addr_a, 0);
    check_eq("t5_async_att", att_a, 0);
    @(negedge clk);
    check_eq("t5_no_done", done_a, 0);
    rst_a = 1'b0;
    wait_done(1'b0, 40, n);
    check_eq("t5_cycles", n, 6);
    check_eq("t5_pass", pass_a, 1);

    // Test 6: start during DONE chains into a new check
    check_eq("t6_done_seen", done_a, 1);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    check_eq("t6_busy", busy_a, 1);
    check_eq("t6_done_drop", done_a, 0);
    check_eq("t6_pass_clr", pass_a, 0);
    check_eq("t6_att", att_a, 1);
    wait_done(1'b0, 40, n);
    check_eq("t6_cycles", n + 1, 6);
    check_eq("t6_pass", pass_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
